// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD control path and its paired datapath.
// Holds the controller state encoding and the default operand width.
// No logic; imported by gcd_ctrl and the datapath.
package gcd_pkg;

  // Default operand width, shared with the datapath so both agree
  localparam int GCD_NUM_WIDTH = 16;

  // Controller states
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CHECK,
    ST_SUB,
    ST_FOUND,
    ST_DONE
  } gcd_state_e;

endpackage

// File: rtl/gcd_ctrl.sv
// Control FSM for the subtractive GCD datapath: load, iterate subtract steps, report.
// Latency: 2*iters+3 normal, 2 on zero operand, 2*MAX_ITER+2 on timeout (accept edge to done_valid).
// Backpressure: start accepted only in IDLE; DONE holds status until done_ready.
module gcd_ctrl
  import gcd_pkg::*;
#(
  parameter int NUM_WIDTH = GCD_NUM_WIDTH,
  parameter int CNT_WIDTH = NUM_WIDTH + 1,
  parameter int MAX_ITER  = 2**NUM_WIDTH
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 start_valid,
  output logic                 start_ready,
  input  logic                 a_zero,
  input  logic                 b_zero,
  input  logic                 equal,
  input  logic                 a_gt_b,
  output logic                 load,
  output logic                 sub_en,
  output logic                 a_sub_b,
  output logic                 found,
  output logic                 done_valid,
  input  logic                 done_ready,
  output logic [CNT_WIDTH-1:0] iter_count,
  output logic                 err_zero,
  output logic                 err_timeout
);

  localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_ITER);

  gcd_state_e           state_q, state_d;
  logic [CNT_WIDTH-1:0] iter_q;
  logic                 a_sub_b_q;
  logic                 err_zero_q;
  logic                 err_timeout_q;
  logic                 start_ready_q;
  logic                 load_q;
  logic                 sub_en_q;
  logic                 found_q;
  logic                 done_valid_q;
  logic                 any_zero;
  logic                 at_limit;

  assign any_zero = a_zero | b_zero;
  assign at_limit = (iter_q == MAX_CNT);

  // Next-state selection; CHECK applies zero > equal > limit > subtract priority
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_valid) state_d = ST_LOAD;
      ST_LOAD:  state_d = ST_CHECK;
      ST_CHECK: begin
        if (any_zero)      state_d = ST_DONE;
        else if (equal)    state_d = ST_FOUND;
        else if (at_limit) state_d = ST_DONE;
        else               state_d = ST_SUB;
      end
      ST_SUB:   state_d = ST_CHECK;
      ST_FOUND: state_d = ST_DONE;
      ST_DONE:  if (done_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State register, strobes decoded from the next state, and status registers
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q       <= ST_IDLE;
      iter_q        <= '0;
      a_sub_b_q     <= 1'b0;
      err_zero_q    <= 1'b0;
      err_timeout_q <= 1'b0;
      start_ready_q <= 1'b1;
      load_q        <= 1'b0;
      sub_en_q      <= 1'b0;
      found_q       <= 1'b0;
      done_valid_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      start_ready_q <= (state_d == ST_IDLE);
      load_q        <= (state_d == ST_LOAD);
      sub_en_q      <= (state_d == ST_SUB);
      found_q       <= (state_d == ST_FOUND);
      done_valid_q  <= (state_d == ST_DONE);

      if (state_q == ST_IDLE && start_valid) begin
        iter_q        <= '0;
        err_zero_q    <= 1'b0;
        err_timeout_q <= 1'b0;
      end

      if (state_q == ST_CHECK) begin
        if (any_zero)             err_zero_q    <= 1'b1;
        else if (equal)           ;
        else if (at_limit)        err_timeout_q <= 1'b1;
        else                      a_sub_b_q     <= a_gt_b;
      end

      // Count completed subtract steps, sticking at all-ones rather than wrapping
      if (state_q == ST_SUB && iter_q != '1) begin
        iter_q <= iter_q + 1'b1;
      end
    end
  end

  assign start_ready = start_ready_q;
  assign load        = load_q;
  assign sub_en      = sub_en_q;
  assign found       = found_q;
  assign done_valid  = done_valid_q;
  assign a_sub_b     = a_sub_b_q;
  assign iter_count  = iter_q;
  assign err_zero    = err_zero_q;
  assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_gcd_ctrl.sv
// Bench for gcd_ctrl: emulated datapath, transaction-level outcome model, per-cycle compare.
module tb_gcd_ctrl;

  localparam int NW   = 8;
  localparam int CW   = NW + 1;
  localparam int MAXI = 4;

  // Outcome kinds
  localparam int K_FOUND   = 0;
  localparam int K_ZERO    = 1;
  localparam int K_TIMEOUT = 2;

  logic          clk = 1'b0;
  logic          n_rst = 1'b0;
  logic          start_valid = 1'b0;
  logic          start_ready;
  logic          a_zero, b_zero, equal, a_gt_b;
  logic          load, sub_en, a_sub_b, found, done_valid;
  logic          done_ready = 1'b0;
  logic [CW-1:0] iter_count;
  logic          err_zero, err_timeout;

  logic [NW-1:0] a_in = '0, b_in = '0;
  logic [NW-1:0] dp_a = '0, dp_b = '0;

  int err_cnt = 0;
  int chk_cnt = 0;

  always #5 clk = ~clk;

  gcd_ctrl #(.NUM_WIDTH(NW), .CNT_WIDTH(CW), .MAX_ITER(MAXI)) dut (
    .clk(clk), .n_rst(n_rst),
    .start_valid(start_valid), .start_ready(start_ready),
    .a_zero(a_zero), .b_zero(b_zero), .equal(equal), .a_gt_b(a_gt_b),
    .load(load), .sub_en(sub_en), .a_sub_b(a_sub_b), .found(found),
    .done_valid(done_valid), .done_ready(done_ready),
    .iter_count(iter_count), .err_zero(err_zero), .err_timeout(err_timeout)
  );

  // Emulated datapath
  assign a_zero = (dp_a == '0);
  assign b_zero = (dp_b == '0);
  assign equal  = (dp_a == dp_b);
  assign a_gt_b = (dp_a > dp_b);

  always @(posedge clk) begin
    if (load) begin
      dp_a <= a_in;
      dp_b <= b_in;
    end else if (sub_en) begin
      if (a_sub_b) dp_a <= dp_a - dp_b;
      else         dp_b <= dp_b - dp_a;
    end
  end

  // Reference: run Euclid-by-subtraction directly on the operands
  typedef struct {
    int          kind;
    int          iters;
    logic [63:0] dirs;
  } res_t;

  function automatic res_t model_run(int a, int b);
    res_t r;
    int x = a;
    int y = b;
    r.kind = K_FOUND; r.iters = 0; r.dirs = '0;
    for (int g = 0; g < 1000; g++) begin
      if (x == 0 || y == 0) begin r.kind = K_ZERO; break; end
      if (x == y)           begin r.kind = K_FOUND; break; end
      if (r.iters == MAXI)  begin r.kind = K_TIMEOUT; break; end
      r.dirs[r.iters] = (x > y);
      if (x > y) x = x - y; else y = y - x;
      r.iters++;
    end
    return r;
  endfunction

  function automatic int done_k(res_t r);
    if (r.kind == K_ZERO)    return 2;
    if (r.kind == K_TIMEOUT) return 2 * r.iters + 2;
    return 2 * r.iters + 3;
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    chk_cnt++;
    if (act != exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Transaction tracker: k = cycles since acceptance edge (0 = first cycle after it)
  bit   model_valid = 1'b0;
  bit   in_txn = 1'b0;
  int   k = 0;
  res_t res;
  int   last_iters = 0;
  bit   last_ez = 1'b0, last_et = 1'b0;

  always @(posedge clk) begin
    if (!n_rst) begin
      model_valid <= 1'b1;
      in_txn      <= 1'b0;
      k           <= 0;
      last_iters  <= 0;
      last_ez     <= 1'b0;
      last_et     <= 1'b0;
    end else if (in_txn) begin
      if (k >= done_k(res) && done_ready) begin
        in_txn     <= 1'b0;
        last_iters <= res.iters;
        last_ez    <= (res.kind == K_ZERO);
        last_et    <= (res.kind == K_TIMEOUT);
      end else begin
        k <= k + 1;
      end
    end else if (start_valid) begin
      in_txn <= 1'b1;
      k      <= 0;
      res    <= model_run(int'(a_in), int'(b_in));
    end
  end

  // Per-cycle compare, plus per-transaction pulse counters
  int sub_cnt = 0, found_cnt = 0, first_done = -1;

  initial begin
    forever begin
      @(negedge clk);
      if (model_valid) begin
        int er, el, es, ef, ed, ei, eez, eet, dk;
        if (in_txn) begin
          dk  = done_k(res);
          er  = 0;
          el  = (k == 0);
          es  = (res.kind != K_ZERO && k >= 2 && (k % 2) == 0 && (k - 2) / 2 < res.iters);
          ef  = (res.kind == K_FOUND && k == 2 + 2 * res.iters);
          ed  = (k >= dk);
          ei  = (k < 3) ? 0 : (((k - 1) / 2 < res.iters) ? (k - 1) / 2 : res.iters);
          eez = (res.kind == K_ZERO && ed);
          eet = (res.kind == K_TIMEOUT && ed);
          if (k == 0) begin sub_cnt = 0; found_cnt = 0; first_done = -1; end
          if (sub_en) sub_cnt++;
          if (found) found_cnt++;
          if (done_valid && first_done < 0) first_done = k;
        end else begin
          er = 1; el = 0; es = 0; ef = 0; ed = 0;
          ei = last_iters; eez = last_ez; eet = last_et;
        end
        chk("start_ready", start_ready, er);
        chk("load", load, el);
        chk("sub_en", sub_en, es);
        chk("found", found, ef);
        chk("done_valid", done_valid, ed);
        chk("iter_count", iter_count, ei);
        chk("err_zero", err_zero, eez);
        chk("err_timeout", err_timeout, eet);
        if (in_txn && es) chk("a_sub_b", a_sub_b, res.dirs[(k - 2) / 2]);
      end
    end
  end

  // Called at a negedge with the controller idle; returns at a negedge, idle again
  task automatic run_txn(input int a, input int b, input int hold, input bit noise, input bit pulse);
    int cyc;
    a_in = NW'(a); b_in = NW'(b);
    start_valid = 1'b1; done_ready = 1'b0;
    @(negedge clk);
    start_valid = 1'b0;
    cyc = 0;
    while (!(in_txn && k >= done_k(res)) && cyc < 300) begin
      if (noise) begin
        done_ready  = 1'($urandom_range(0, 1));
        start_valid = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 300) begin
      err_cnt++;
      $display("FAIL wait_done: got no completion within %0d cycles", cyc);
    end
    start_valid = 1'b0; done_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      start_valid = (pulse && i == 2);
      @(negedge clk);
    end
    start_valid = 1'b0;
    done_ready = 1'b1;
    @(negedge clk);
    done_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected finish before 1 ms");
    $fatal(1);
  end

  initial begin
    res_t r;
    // Pin the reference model with hand-worked cases
    r = model_run(6, 4);
    chk("model_6_4_kind", r.kind, K_FOUND);
    chk("model_6_4_iters", r.iters, 2);
    chk("model_6_4_dirs", r.dirs[1:0], 2'b01);
    r = model_run(9, 1);
    chk("model_9_1_kind", r.kind, K_TIMEOUT);
    chk("model_9_1_iters", r.iters, 4);
    r = model_run(0, 7);
    chk("model_0_7_kind", r.kind, K_ZERO);

    repeat (2) @(posedge clk);
    @(negedge clk);
    n_rst = 1'b1;
    chk("reset_start_ready", start_ready, 1);
    chk("reset_iter_count", iter_count, 0);

    // Reset in the middle of the second subtract step
    a_in = 9; b_in = 6; start_valid = 1'b1;
    @(negedge clk);
    start_valid = 1'b0;
    for (int i = 0; i < 50 && !(in_txn && k == 4); i++) @(negedge clk);
    chk("mid_sub_state", sub_en, 1);
    chk("mid_sub_iter", iter_count, 1);
    n_rst = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
    chk("rst_mid_start_ready", start_ready, 1);
    chk("rst_mid_iter_count", iter_count, 0);
    chk("rst_mid_done_valid", done_valid, 0);
    chk("rst_mid_found", found, 0);

    run_txn(6, 4, 0, 0, 0);
    chk("lat_6_4", first_done, 7);
    chk("subs_6_4", sub_cnt, 2);
    chk("found_6_4", found_cnt, 1);
    chk("iters_6_4", iter_count, 2);

    run_txn(5, 5, 1, 0, 0);
    chk("lat_5_5", first_done, 3);
    chk("subs_5_5", sub_cnt, 0);
    chk("iters_5_5", iter_count, 0);

    run_txn(0, 7, 0, 0, 0);
    chk("lat_0_7", first_done, 2);
    chk("found_0_7", found_cnt, 0);
    chk("subs_0_7", sub_cnt, 0);
    chk("err_zero_0_7", err_zero, 1);

    run_txn(9, 1, 0, 0, 0);
    chk("lat_9_1", first_done, 2 * MAXI + 2);
    chk("subs_9_1", sub_cnt, 4);
    chk("found_9_1", found_cnt, 0);
    chk("err_timeout_9_1", err_timeout, 1);
    chk("iters_9_1", iter_count, 4);

    // Completion held for 5 cycles with a stray start request
    run_txn(6, 4, 5, 0, 1);
    chk("hold_start_ready", start_ready, 1);
    chk("hold_iters", iter_count, 2);
    run_txn(5, 5, 0, 0, 0);
    chk("after_hold_lat", first_done, 3);

    // Randomized operands, noisy handshakes, random completion stalls
    for (int t = 0; t < 60; t++) begin
      run_txn($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 3), 1, $urandom_range(0, 1));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
